// File: rtl/io_pattern_monitor.sv
// io_pattern_monitor: checks that an asynchronous bus walks through a programmed table of masked
// values, each value seen on STABLE_CYCLES consecutive synchronized samples, within a per-step cycle limit.
// Latency: 2-cycle synchronizer on bus_in; status outputs change one clock after the deciding sample.
// Backpressure: none; bus_in is sampled every cycle and a stalled step ends in FAIL after TIMEOUT_CYCLES.
//
// Ports:
//   CLK, resetn             - sole clock, synchronous active-low reset (table contents survive reset)
//   bus_in                  - asynchronous pins under observation
//   load_en/addr/data/mask  - sequence-table write port, ignored while a check is running
//   seq_len                 - number of steps, sampled on start (clamped to DEPTH)
//   start, abort            - single-cycle controls; abort wins over start
//   busy, done, pass, fail  - status; PASS/FAIL hold until start, abort or reset
//   step_idx, stall_cnt     - current (or failing) step and cycles spent in it
module io_pattern_monitor #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int AW            = $clog2(DEPTH),
    localparam int TW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] load_mask,
    input  logic [AW:0]      seq_len,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [AW:0]      step_idx,
    output logic [TW-1:0]    stall_cnt
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      step_q, step_d;
    logic [TW-1:0]    stall_q, stall_d;
    logic [SW-1:0]    stable_q, stable_d;

    // Sequence table: deliberately not reset so a program survives a reset.
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (load_en && (state_q != S_RUN)) begin
            data_mem[load_addr] <= load_data;
            mask_mem[load_addr] <= load_mask;
        end
    end

    logic [WIDTH-1:0] cur_data, cur_mask;
    logic             match, advance;
    logic [AW:0]      len_clamp, step_inc;
    logic [TW-1:0]    stall_inc;
    logic [SW-1:0]    stable_inc;

    // step_q only indexes the table while RUN, where step_q < len_q <= DEPTH.
    assign cur_data   = data_mem[step_q[AW-1:0]];
    assign cur_mask   = mask_mem[step_q[AW-1:0]];
    assign match      = ((sync2_q ^ cur_data) & cur_mask) == '0;
    assign stable_inc = stable_q + SW'(1);
    assign advance    = match && (stable_inc == SW'(STABLE_CYCLES));
    assign step_inc   = step_q + (AW+1)'(1);
    // While RUN, stall_q < TIMEOUT_CYCLES, so the increment cannot overflow TW bits.
    assign stall_inc  = stall_q + TW'(1);
    assign len_clamp  = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            len_q    <= '0;
            step_q   <= '0;
            stall_q  <= '0;
            stable_q <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus_in;
            sync2_q  <= sync1_q;
            len_q    <= len_d;
            step_q   <= step_d;
            stall_q  <= stall_d;
            stable_q <= stable_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        step_d   = step_q;
        stall_d  = stall_q;
        stable_d = stable_q;
        if (abort) begin
            state_d  = S_IDLE;
            step_d   = '0;
            stall_d  = '0;
            stable_d = '0;
        end else if (state_q != S_RUN) begin
            if (start) begin
                len_d    = len_clamp;
                step_d   = '0;
                stall_d  = '0;
                stable_d = '0;
                // An empty sequence completes immediately without running.
                state_d  = (len_clamp == '0) ? S_PASS : S_RUN;
            end
        end else if (advance) begin
            // Advance beats a timeout landing on the same cycle; the stable
            // window restarts so repeated entries each need a full window.
            step_d   = step_inc;
            stall_d  = '0;
            stable_d = '0;
            if (step_inc == len_q) begin
                state_d = S_PASS;
            end
        end else begin
            stable_d = match ? stable_inc : '0;
            stall_d  = stall_inc;
            if (stall_inc == TW'(TIMEOUT_CYCLES)) begin
                state_d = S_FAIL;
            end
        end
    end

    // Output decode
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        fail      = 1'b0;
        step_idx  = step_q;
        stall_cnt = stall_q;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_PASS:  begin done = 1'b1; pass = 1'b1; end
            S_FAIL:  begin done = 1'b1; fail = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_pattern_monitor.sv
// tb_io_pattern_monitor: table vectors, directed corner sequences and randomized traces
// checked against a window-search model of the pattern rules.
// Clock period 10; inputs driven at negedge, outputs sampled at negedge.
module tb_io_pattern_monitor;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 50;
    localparam int AW      = $clog2(DEPTH);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int TRN     = 512;

    logic             CLK = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] bus_in;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] load_mask;
    logic [AW:0]      seq_len;
    logic             start;
    logic             abort;
    logic             busy, done, pass, fail;
    logic [AW:0]      step_idx;
    logic [TW-1:0]    stall_cnt;

    always #5 CLK = ~CLK;

    io_pattern_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK(CLK), .resetn(resetn), .bus_in(bus_in),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_mask(load_mask),
        .seq_len(seq_len), .start(start), .abort(abort),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .step_idx(step_idx), .stall_cnt(stall_cnt)
    );

    int vec  = 0;
    int errs = 0;

    logic [7:0] tr [TRN];        // bus value driven ahead of each edge of a run
    int         tc;
    logic [7:0] m_data [DEPTH];
    logic [7:0] m_mask [DEPTH];
    int         run_load_c = -1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] mask;
        logic [7:0] bus;
        bit         exp_pass;
        int         exp_step;
        int         exp_stall;
        int         exp_c;
    } vec_t;
    vec_t vt [8];

    logic [7:0] seq12 [12];

    task automatic chk(input string nm, input int got, input int exp);
        vec++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input bit st, input bit ab);
        @(negedge CLK);
        bus_in = tr[tc];
        if (tc < TRN - 1) tc++;
        start = st;
        abort = ab;
    endtask

    task automatic load_entry(input int a, input logic [7:0] d, input logic [7:0] m);
        @(negedge CLK);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        load_mask = m;
        m_data[a] = d;
        m_mask[a] = m;
        @(negedge CLK);
        load_en   = 1'b0;
    endtask

    function automatic bit mt(input logic [7:0] v, input int k);
        return ((v ^ m_data[k]) & m_mask[k]) == 8'h00;
    endfunction

    // Each step k begins at sample st; it completes at the first sample t whose
    // trailing STABLE samples (all at or after st) match entry k, provided t is
    // within the first TIMEOUT samples of the step; otherwise the run fails on
    // sample st+TIMEOUT-1. The result is seen on done at observation index t+3.
    task automatic model(input int len, output bit ok, output int stp, output int stl,
                         output int exp_c);
        int st;
        st = 0;
        for (int k = 0; k < len; k++) begin
            int found;
            found = -1;
            for (int t = st + STABLE - 1; t <= st + TIMEOUT - 1; t++) begin
                bit all;
                all = 1'b1;
                for (int u = t - STABLE + 1; u <= t; u++)
                    if (!mt(tr[u], k)) all = 1'b0;
                if (all) begin
                    found = t;
                    break;
                end
            end
            if (found < 0) begin
                ok = 1'b0; stp = k; stl = TIMEOUT; exp_c = st + TIMEOUT - 1 + 3;
                return;
            end
            st = found + 1;
        end
        ok = 1'b1; stp = len; stl = 0; exp_c = st - 1 + 3;
    endtask

    task automatic run_and_check(input string nm, input int len, input bit exp_ok,
                                 input int exp_step, input int exp_stall, input int exp_c);
        int got;
        tc      = 0;
        seq_len = (AW+1)'(len);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        got = -1;
        for (int c = 2; c < TRN + 100; c++) begin
            drive(1'b0, 1'b0);
            load_en = (c == run_load_c);
            if (c == 2) begin
                chk({nm, "/busy_after_start"}, int'(busy), 1);
                chk({nm, "/done_clear_after_start"}, int'(done), 0);
            end
            if (done) begin
                got = c;
                break;
            end
        end
        load_en = 1'b0;
        if (got < 0) begin
            vec++;
            errs++;
            $display("FAIL %s/no_done: done never rose within %0d cycles", nm, TRN + 100);
        end else begin
            chk({nm, "/done_cycle"}, got, exp_c);
            chk({nm, "/pass"}, int'(pass), int'(exp_ok));
            chk({nm, "/fail"}, int'(fail), int'(!exp_ok));
            chk({nm, "/step_idx"}, int'(step_idx), exp_step);
            chk({nm, "/stall_cnt"}, int'(stall_cnt), exp_stall);
            repeat (3) drive(1'b0, 1'b0);
            chk({nm, "/done_hold"}, int'(done), 1);
        end
    endtask

    task automatic gen_trace(input int len);
        int k, i, dur, r;
        logic [7:0] v;
        k = 0;
        i = 0;
        while (i < TRN) begin
            dur = $urandom_range(1, 5);
            r   = $urandom_range(0, 99);
            if (r < 6) dur = 60;
            if (r < 30) v = 8'($urandom);
            else v = (m_data[k % len] & m_mask[k % len]) | (8'($urandom) & ~m_mask[k % len]);
            for (int u = 0; u < dur && i < TRN; u++) begin
                tr[i] = v;
                i++;
            end
            if (r >= 30 && dur >= 2) k++;
        end
    endtask

    task automatic load_seq12();
        for (int a = 0; a < 12; a++) load_entry(a, seq12[a], 8'hFF);
    endtask

    task automatic run_to_step(input string nm, input int target);
        int hit;
        tc      = 0;
        seq_len = 5'd12;
        for (int i = 0; i < TRN; i++) tr[i] = seq12[(i / 4 < 12) ? i / 4 : 11];
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        hit = 0;
        for (int c = 2; c < 200; c++) begin
            drive(1'b0, 1'b0);
            if (int'(step_idx) == target) begin
                hit = 1;
                break;
            end
        end
        chk({nm, "/reached_step"}, hit, 1);
        chk({nm, "/busy_at_step"}, int'(busy), 1);
    endtask

    initial begin
        bit ok;
        int stp, stl, ec, len;

        for (int i = 0; i < 10; i++) seq12[i] = 8'(i + 1);
        seq12[10] = 8'hFF;
        seq12[11] = 8'h00;

        // {data, mask, bus, pass?, step, stall, done observation index}
        vt[0] = '{8'h5A, 8'hFF, 8'h5A, 1'b1, 1, 0, 4};
        vt[1] = '{8'h5A, 8'hF0, 8'h53, 1'b1, 1, 0, 4};
        vt[2] = '{8'h5A, 8'hF0, 8'h4A, 1'b0, 0, 50, 52};
        vt[3] = '{8'h00, 8'h00, 8'hC3, 1'b1, 1, 0, 4};
        vt[4] = '{8'h80, 8'h80, 8'hFF, 1'b1, 1, 0, 4};
        vt[5] = '{8'h80, 8'h80, 8'h7F, 1'b0, 0, 50, 52};
        vt[6] = '{8'h0F, 8'h0F, 8'hF0, 1'b0, 0, 50, 52};
        vt[7] = '{8'h0F, 8'h0F, 8'hFF, 1'b1, 1, 0, 4};

        resetn = 1'b0; bus_in = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        load_mask = '0; seq_len = '0; start = 1'b0; abort = 1'b0; tc = 0;
        for (int i = 0; i < TRN; i++) tr[i] = 8'h00;

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("reset/busy", int'(busy), 0);
        chk("reset/done", int'(done), 0);
        chk("reset/pass", int'(pass), 0);
        chk("reset/fail", int'(fail), 0);
        chk("reset/step_idx", int'(step_idx), 0);
        chk("reset/stall_cnt", int'(stall_cnt), 0);
        resetn = 1'b1;

        // Single-entry match rules with the bus held constant
        for (int v = 0; v < 8; v++) begin
            load_entry(0, vt[v].data, vt[v].mask);
            for (int i = 0; i < TRN; i++) tr[i] = vt[v].bus;
            run_and_check($sformatf("vec%0d", v), 1, vt[v].exp_pass, vt[v].exp_step,
                          vt[v].exp_stall, vt[v].exp_c);
        end

        // seq_len above DEPTH clamps to DEPTH; all-zero masks match anything
        for (int a = 0; a < DEPTH; a++) load_entry(a, 8'(a), 8'h00);
        for (int i = 0; i < TRN; i++) tr[i] = 8'h3C;
        run_and_check("clamp", 31, 1'b1, 16, 0, 34);

        // Twelve-step sequence, each value held 4 cycles
        load_seq12();
        for (int i = 0; i < TRN; i++) tr[i] = seq12[(i / 4 < 12) ? i / 4 : 11];
        run_and_check("seq12", 12, 1'b1, 12, 0, 48);

        // Bus stalls on 0x05: step 5 times out
        for (int i = 0; i < TRN; i++) tr[i] = (i / 4 < 5) ? 8'(i / 4 + 1) : 8'h05;
        run_and_check("timeout", 12, 1'b0, 5, 50, 70);

        // Single-cycle 0x03 glitch between 0x02 holds must not advance step 2
        for (int i = 0; i < TRN; i++) tr[i] = (i < 4) ? 8'h01 : ((i == 8) ? 8'h03 : 8'h02);
        run_and_check("glitch", 3, 1'b0, 2, 50, 58);

        // Identical consecutive entries each need a fresh window; a load
        // attempted mid-run must not disturb the table
        load_entry(0, 8'hAA, 8'hFF);
        load_entry(1, 8'hAA, 8'hFF);
        load_addr = 4'd1; load_data = 8'h55; load_mask = 8'hFF;
        run_load_c = 3;
        for (int i = 0; i < TRN; i++) tr[i] = 8'hAA;
        run_and_check("repeat_aa", 2, 1'b1, 2, 0, 6);
        run_load_c = -1;

        // Abort out of PASS, then an empty sequence passes on the next cycle
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("abort_pass/pass", int'(pass), 0);
        chk("abort_pass/done", int'(done), 0);
        seq_len = '0;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        chk("len0/pass", int'(pass), 1);
        chk("len0/busy", int'(busy), 0);

        // Abort during RUN at step 3
        load_seq12();
        run_to_step("abort3", 3);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("abort3/busy", int'(busy), 0);
        chk("abort3/done", int'(done), 0);
        chk("abort3/pass", int'(pass), 0);
        chk("abort3/fail", int'(fail), 0);

        // Abort beats a simultaneous start
        seq_len = 5'd12;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        chk("abort_vs_start/busy", int'(busy), 0);

        // Reset mid-RUN at step 4, then rerun on the retained table
        run_to_step("reset4", 4);
        resetn = 1'b0;
        drive(1'b0, 1'b0);
        chk("reset4/busy", int'(busy), 0);
        chk("reset4/done", int'(done), 0);
        chk("reset4/pass", int'(pass), 0);
        chk("reset4/fail", int'(fail), 0);
        chk("reset4/step_idx", int'(step_idx), 0);
        chk("reset4/stall_cnt", int'(stall_cnt), 0);
        resetn = 1'b1;
        for (int i = 0; i < TRN; i++) tr[i] = seq12[(i / 4 < 12) ? i / 4 : 11];
        run_and_check("rerun", 12, 1'b1, 12, 0, 48);

        // Randomized tables and traces against the model
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(1, 5);
            for (int a = 0; a < 5; a++)
                load_entry(a, 8'($urandom), ($urandom_range(0, 99) < 15) ? 8'h00 : 8'($urandom));
            gen_trace(len);
            model(len, ok, stp, stl, ec);
            run_and_check($sformatf("rand%0d", n), len, ok, stp, stl, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_pattern_monitor.md
IO_PATTERN_MONITOR -- requirements
Module: io_pattern_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, monitored bus width.
REQ-002 The block SHALL have parameter DEPTH, default 16, maximum expected-sequence entries; AW = clog2(DEPTH).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 2, consecutive matching samples required per step (minimum 1).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, per-step cycle limit; TW = clog2(TIMEOUT_CYCLES+1).
REQ-005 The block SHALL have port CLK, input, 1, sole clock.
REQ-006 The block SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-007 The block SHALL have port bus_in, input, WIDTH, asynchronous pins under observation.
REQ-008 The block SHALL have ports load_en (1), load_addr (AW), load_data (WIDTH), load_mask (WIDTH), inputs, sequence-table write port.
REQ-009 The block SHALL have port seq_len, input, AW+1, number of steps; sampled on start.
REQ-010 The block SHALL have ports start and abort, inputs, 1, single-cycle controls.
REQ-011 The block SHALL have outputs busy, done, pass, fail, each 1.
REQ-012 The block SHALL have output step_idx, AW+1, current or failing step index.
REQ-013 The block SHALL have output stall_cnt, TW, cycles spent in current step.

Function
REQ-014 bus_in SHALL pass through a 2-flop synchronizer; all compares use the synchronized value (2-cycle input latency).
REQ-015 Table write: when load_en=1 and state is IDLE, PASS or FAIL, entry load_addr SHALL store {load_data, load_mask} on the clock edge; writes while RUN SHALL be ignored.
REQ-016 A sample matches step k when (sync_bus & mask[k]) == (data[k] & mask[k]); mask all-zero matches unconditionally.
REQ-017 States SHALL be IDLE, RUN, PASS, FAIL.
REQ-018 IDLE/PASS/FAIL + start=1: latch seq_len, clear step_idx, stall_cnt and stable counter, enter RUN; done, pass, fail deassert the next cycle.
REQ-019 start with latched seq_len=0 SHALL enter PASS one cycle after start, without entering RUN.
REQ-020 seq_len > DEPTH SHALL be clamped to DEPTH.
REQ-021 RUN: stable counter increments on each matching sample, clears on any non-matching sample.
REQ-022 RUN: when stable counter reaches STABLE_CYCLES, step_idx increments, stable counter and stall_cnt clear in the same cycle.
REQ-023 The stable window SHALL restart after every advance, so identical consecutive entries each require a fresh STABLE_CYCLES window.
REQ-024 When step_idx reaches seq_len, the state SHALL be PASS on the same edge.
REQ-025 RUN: stall_cnt increments each cycle without advance; when stall_cnt reaches TIMEOUT_CYCLES, enter FAIL with step_idx frozen at the stalled step.
REQ-026 Advance and timeout on the same cycle: advance wins.
REQ-027 abort=1 in any state SHALL enter IDLE next cycle, clearing done, pass, fail; abort has priority over start.
REQ-028 busy=1 exactly in RUN; done=1 in PASS or FAIL; pass=1 only in PASS; fail=1 only in FAIL; PASS and FAIL SHALL hold until start, abort or reset.
REQ-029 stall_cnt SHALL saturate at TIMEOUT_CYCLES and hold in FAIL.

Reset
REQ-030 resetn=0 at a clock edge SHALL force IDLE, busy=done=pass=fail=0, step_idx=0, stall_cnt=0, synchronizer flops to 0, mid-operation included.
REQ-031 Sequence table contents SHALL be retained across reset.

Verification
REQ-032 Load 0x01..0x0A, 0xFF, 0x00 (mask 0xFF), seq_len=12, drive bus through that sequence holding each value 4 cycles -> pass=1, step_idx=12, fail=0.
REQ-033 Same table, bus stalls at 0x05 with TIMEOUT_CYCLES=50 -> fail=1 after 50 cycles in step 5, step_idx=5, stall_cnt=50.
REQ-034 STABLE_CYCLES=2, bus shows 0x03 for 1 cycle between 0x02 holds -> no advance past step 2 on the glitch.
REQ-035 Entries 0xAA, 0xAA with bus held at 0xAA -> pass exactly 2*STABLE_CYCLES cycles after matching begins (plus synchronizer latency).
REQ-036 seq_len=0 + start -> pass=1 next cycle; abort during RUN at step 3 -> IDLE, busy=0, done=0.
REQ-037 resetn=0 mid-RUN at step 4 -> IDLE with all outputs zero; restart with start reruns from step 0 using retained table.
